// File: rtl/btn_intr_sched_pkg.sv
// Shared types and width helpers for the button-to-interrupt scheduler.
// INTR_TIMEOUT_EN selects whether the ASSERT dwell timeout is built.
package btn_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

`ifdef INTR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Bits needed for a counter running 0 .. n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The dwell counter times GAP and, when the timeout is built, ASSERT too.
  function automatic int dwell_w(input int gap_cyc, input int ack_timeout, input bit tmo_en);
    return cnt_w((tmo_en && (ack_timeout > gap_cyc)) ? ack_timeout : gap_cyc);
  endfunction

endpackage

// File: rtl/btn_intr_sched_if.sv
// Interrupt handshake between the scheduler (master) and the TramelBlaze (slave).
interface btn_intr_sched_if;
  logic interrupt;
  logic intr_ack;
  logic dir_out;

  modport master (output interrupt, output dir_out, input intr_ack);
  modport slave  (input interrupt, input dir_out, output intr_ack);
endinterface

// File: rtl/btn_intr_sched_debounce.sv
// Two-flop synchroniser plus stability counter: db_level_o follows btn_i only
// after the synchronised input has differed from it for DB_TICKS cycles.
module debounce_filter
  import btn_intr_pkg::*;
#(
  parameter int DB_TICKS = 2_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic db_level_o
);

  localparam int            CW   = cnt_w(DB_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where input and level agree restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) level_d = sync2_q;
      else               cnt_d   = cnt_q + CW'(1);
    end
  end

  assign db_level_o = level_q;

endmodule

// File: rtl/btn_intr_sched.sv
// Turns debounced button presses into one TramelBlaze interrupt each, queuing
// presses while an interrupt is outstanding. Define INTR_TIMEOUT_EN to abandon
// an interrupt that is not acknowledged within ACK_TIMEOUT cycles.
module btn_intr_sched
  import btn_intr_pkg::*;
#(
  parameter int DB_TICKS    = 2_000_000,
  parameter int PEND_W      = 4,
  parameter int GAP_CYC     = 4,
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_in,
  input  logic                sw_uhdl,
  btn_intr_sched_if.master    bus,
  output logic [PEND_W-1:0]   pend_cnt,
  output logic                db_level,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int                DW_W     = dwell_w(GAP_CYC, ACK_TIMEOUT, TMO_EN);
  localparam logic [DW_W-1:0]   GAP_LAST = DW_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              sw_s1_q, sw_s2_q;
  logic              db_level_q;
  logic              dir_q, dir_d;
  logic              ovf_q, ovf_d;
  logic              irq;
  logic              press, issue, expired;

  debounce_filter #(.DB_TICKS(DB_TICKS)) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_i      (btn_in),
    .db_level_o (db_level)
  );

  assign press = db_level & ~db_level_q;
  assign issue = (state_q == ST_IDLE) && (pend_q != '0);

`ifdef INTR_TIMEOUT_EN
  localparam logic [DW_W-1:0] TMO_LAST = DW_W'(ACK_TIMEOUT - 1);
  logic tmo_q;

  // An ack on the final cycle wins; the abandoned event is not re-queued.
  assign expired = (state_q == ST_ASSERT) && (dwell_q == TMO_LAST) && !bus.intr_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= 1'b0;
    else          tmo_q <= tmo_q | expired;
  end

  assign timeout_err = tmo_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state logic; intr_ack only matters while asserting.
  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (bus.intr_ack || expired) state_d = ST_GAP;
`ifdef INTR_TIMEOUT_EN
        else                         dwell_d = dwell_q + DW_W'(1);
`endif
      end
      ST_GAP: begin
        if (dwell_q == GAP_LAST) state_d = ST_IDLE;
        else                     dwell_d = dwell_q + DW_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    irq = (state_q == ST_ASSERT);
  end

  // Pending-press counter, overflow flag and direction latch.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    dir_d  = issue ? sw_s2_q : dir_q;
    if (press && !issue) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end else if (issue && !press) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q    <= 1'b0;
      sw_s2_q    <= 1'b0;
      db_level_q <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      sw_s1_q    <= sw_uhdl;
      sw_s2_q    <= sw_s1_q;
      db_level_q <= db_level;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      dir_q      <= dir_d;
    end
  end

  assign bus.interrupt = irq;
  assign bus.dir_out   = dir_q;
  assign pend_cnt      = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_btn_intr_sched.sv
// Scoreboarded bench for btn_intr_sched: stimulus queues the expected direction
// of every interrupt a press should produce; a monitor checks each rising edge.
module tb_btn_intr_sched;

  localparam int DB_TICKS    = 16;
  localparam int GAP_CYC     = 4;
  localparam int PEND_W      = 2;
  localparam int ACK_TIMEOUT = 100;
  localparam int PEND_MAX    = (1 << PEND_W) - 1;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic              btn_in  = 1'b0;
  logic              sw_uhdl = 1'b0;
  logic [PEND_W-1:0] pend_cnt;
  logic              db_level, overflow, timeout_err;

  btn_intr_sched_if bus();

  btn_intr_sched #(
    .DB_TICKS    (DB_TICKS),
    .PEND_W      (PEND_W),
    .GAP_CYC     (GAP_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .sw_uhdl     (sw_uhdl),
    .bus         (bus),
    .pend_cnt    (pend_cnt),
    .db_level    (db_level),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_bad      = 0;
  int rise_count = 0;
  bit exp_q[$];
  int gap_log[$];
  bit auto_ack   = 1'b0;
  int ack_min    = 1;
  int ack_max    = 4;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    chk(name, act == exp, act, exp);
  endtask

  function automatic int outs_now();
    return int'({bus.interrupt, bus.dir_out, pend_cnt, db_level, overflow, timeout_err});
  endfunction

  // Async reset asserted mid-cycle: outputs must clear before the next edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    btn_in  = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk_eq(name, outs_now(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One press with optional sub-threshold glitches in front; sw_uhdl is held.
  task automatic press(input bit expect_irq, input int bounces);
    if (expect_irq) exp_q.push_back(sw_uhdl);
    for (int i = 0; i < bounces; i++) begin
      btn_in = 1'b1;
      repeat ($urandom_range(10, 1)) @(negedge clk);
      btn_in = 1'b0;
      repeat ($urandom_range(10, 1)) @(negedge clk);
    end
    btn_in = 1'b1;
    repeat (DB_TICKS + 6) @(negedge clk);
    btn_in = 1'b0;
    repeat (DB_TICKS + 6) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.interrupt || pend_cnt != '0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, k < 2000, k, 2000);
    repeat (GAP_CYC + 2) @(negedge clk);
  endtask

  // Monitor: every interrupt rise consumes one expectation.
  initial begin : monitor
    bit prev;
    int ncyc, fall_at, gap;
    bit e;
    prev = 1'b0; ncyc = 0; fall_at = -1;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        prev = 1'b0;
        fall_at = -1;
      end else begin
        if (bus.interrupt && !prev) begin
          rise_count++;
          if (exp_q.size() == 0) begin
            chk("irq_expected", 1'b0, rise_count, 0);
          end else begin
            e = exp_q.pop_front();
            chk_eq("dir_out_at_issue", bus.dir_out, e);
          end
          if (fall_at >= 0) begin
            gap = ncyc - fall_at;
            gap_log.push_back(gap);
            chk("irq_gap_min", gap >= GAP_CYC + 1, gap, GAP_CYC + 1);
          end
          $display("[%0t] irq #%0d dir_out=%0d pend_cnt=%0d", $time, rise_count, bus.dir_out, pend_cnt);
        end
        if (!bus.interrupt && prev) fall_at = ncyc;
        prev = bus.interrupt;
      end
    end
  end

  // CPU model: acknowledges after a random delay, interrupt must drop on that edge.
  initial begin : acker
    int d;
    bus.intr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && reset_n && bus.interrupt) begin
        d = $urandom_range(ack_max, ack_min);
        repeat (d) @(negedge clk);
        if (auto_ack && reset_n && bus.interrupt) begin
          bus.intr_ack = 1'b1;
          @(negedge clk);
          bus.intr_ack = 1'b0;
          chk_eq("ack_drops_irq", bus.interrupt, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  k, drops, base, n;
    bit  db_seen;

    // 1: reset during clock activity, then quiet idle.
    repeat (5) @(negedge clk);
    do_reset("t1_reset_outputs");
    repeat (50) @(negedge clk);
    chk_eq("t1_idle_outputs", outs_now(), 0);

    // 2: bounced press, latency through debounce and scheduler.
    sw_uhdl  = 1'b1;
    auto_ack = 1'b1; ack_min = 2; ack_max = 6;
    repeat (4) @(negedge clk);
    exp_q.push_back(1'b1);
    db_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_in = 1'b1;
      repeat (5) begin @(negedge clk); if (db_level) db_seen = 1'b1; end
      btn_in = 1'b0;
      repeat (5) begin @(negedge clk); if (db_level) db_seen = 1'b1; end
    end
    chk_eq("t2_bounce_filtered", db_seen, 0);
    btn_in = 1'b1;
    k = 0;
    while (!db_level && k < 100) begin @(negedge clk); k++; end
    chk_eq("t2_db_latency", k, DB_TICKS + 2);
    k = 0;
    while (!bus.interrupt && k < 20) begin @(negedge clk); k++; end
    chk_eq("t2_irq_latency", k, 2);
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    repeat (DB_TICKS + 6) @(negedge clk);
    wait_drain("t2_drain");
    sw_uhdl = 1'b0;
    repeat (6) @(negedge clk);
    chk_eq("t2_dir_out_hold", bus.dir_out, 1);

    // 3: three presses before any ack, then paced re-issue.
    auto_ack = 1'b0;
    gap_log.delete();
    base = rise_count;
    for (int p = 0; p < 3; p++) begin
      press(1'b1, 0);
`ifndef INTR_TIMEOUT_EN
      chk_eq("t3_pend_after_press", pend_cnt, p);
`endif
    end
    ack_min = 1; ack_max = 8;
    auto_ack = 1'b1;
    wait_drain("t3_drain");
    chk_eq("t3_irq_count", rise_count - base, 3);
    chk_eq("t3_gap_entries", gap_log.size(), 3);
    if (gap_log.size() == 3) begin
      chk_eq("t3_gap_second", gap_log[1], GAP_CYC + 1);
      chk_eq("t3_gap_third", gap_log[2], GAP_CYC + 1);
    end

`ifndef INTR_TIMEOUT_EN
    // 4: saturate the queue with no acks; 5: interrupt held without timeout.
    auto_ack = 1'b0;
    sw_uhdl  = 1'b1;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 4; p++) press(1'b1, 0);
    chk_eq("t4_pend_full", pend_cnt, PEND_MAX);
    chk_eq("t4_no_overflow_yet", overflow, 0);
    press(1'b0, 0);
    chk_eq("t4_pend_saturated", pend_cnt, PEND_MAX);
    chk_eq("t4_overflow_set", overflow, 1);
    press(1'b0, 1);
    chk_eq("t4_pend_still_sat", pend_cnt, PEND_MAX);
    chk_eq("t4_overflow_sticky", overflow, 1);
    drops = 0;
    repeat (1000) begin @(negedge clk); if (!bus.interrupt) drops++; end
    chk_eq("t5_irq_held", drops, 0);
    chk_eq("t5_timeout_err_zero", timeout_err, 0);
    do_reset("t4_reset_clears");
`else
    // 5: unacknowledged interrupt is abandoned after ACK_TIMEOUT cycles.
    do_reset("t5_pre_reset");
    auto_ack = 1'b0;
    sw_uhdl  = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(1'b1);
    btn_in = 1'b1;
    k = 0;
    while (!bus.interrupt && k < 60) begin @(negedge clk); k++; end
    chk_eq("t5_rise_latency", k, DB_TICKS + 4);
    k = 0;
    while (bus.interrupt && k < 300) begin @(negedge clk); k++; end
    chk_eq("t5_timeout_fall", k, ACK_TIMEOUT);
    chk_eq("t5_timeout_err_set", timeout_err, 1);
    btn_in = 1'b0;
    repeat (DB_TICKS + 6) @(negedge clk);
    chk_eq("t5_not_requeued", pend_cnt, 0);
    do_reset("t5_reset_clears");
`endif

    // 6: reset while asserting with presses queued.
    auto_ack = 1'b0;
    sw_uhdl  = 1'b1;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 3; p++) press(1'b1, 0);
`ifndef INTR_TIMEOUT_EN
    chk_eq("t6_pend_before_reset", pend_cnt, 2);
    chk_eq("t6_irq_before_reset", bus.interrupt, 1);
`endif
    do_reset("t6_reset_mid_assert");
    repeat (5) @(negedge clk);

    // Randomised rounds: n presses (n<=4 cannot overflow) yield n interrupts.
    for (int r = 0; r < 8; r++) begin
      sw_uhdl = 1'($urandom_range(1, 0));
      repeat (4) @(negedge clk);
      n        = $urandom_range(4, 1);
      base     = rise_count;
      ack_min  = 0;
      ack_max  = $urandom_range(40, 0);
      auto_ack = 1'b1;
      for (int p = 0; p < n; p++) begin
        press(1'b1, $urandom_range(3, 0));
        repeat ($urandom_range(20, 0)) @(negedge clk);
      end
      wait_drain("rand_drain");
      chk_eq("rand_irq_count", rise_count - base, n);
      chk_eq("rand_overflow_clear", overflow, 0);
      chk_eq("rand_dir_out", bus.dir_out, sw_uhdl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
